// File: rtl/div_frac_avg_pkg.sv
// Shared types for the divider averaging block and other ratio checkers.
// Holds the FSM encoding and the accumulator width rule.
package div_frac_avg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACC  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    // N samples of DATA_W bits sum into DATA_W+LOG2_LEN bits without overflow
    function automatic int acc_width(input int data_w, input int log2_len);
        return data_w + log2_len;
    endfunction

endpackage

// File: rtl/div_frac_avg_acc.sv
// Sample accumulator and sample counter for div_frac_avg.
// last_o flags that the next add is sample N.
module div_frac_avg_acc
    import div_frac_avg_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int LOG2_LEN = 8,
    parameter int ACC_W    = acc_width(DATA_W, LOG2_LEN)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              add_i,
    input  logic [DATA_W-1:0] sample_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              last_o
);

    logic [ACC_W-1:0]    sum_q;
    logic [ACC_W-1:0]    sum_d;
    logic [LOG2_LEN-1:0] cnt_q;
    logic [LOG2_LEN-1:0] cnt_d;
    logic [ACC_W-1:0]    sample_ext;

    assign sample_ext = ACC_W'(sample_i);

    always_comb begin
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            sum_d = '0;
            cnt_d = '0;
        end else if (load_i) begin
            sum_d = sample_ext;
            cnt_d = LOG2_LEN'(1);
        end else if (add_i) begin
            sum_d = sum_q + sample_ext;
            cnt_d = cnt_q + LOG2_LEN'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q <= '0;
            cnt_q <= '0;
        end else begin
            sum_q <= sum_d;
            cnt_q <= cnt_d;
        end
    end

    assign sum_o = sum_q;
    // cnt counts 0..N-1, so all-ones means N-1 samples already taken
    assign last_o = &cnt_q;

endmodule

// File: rtl/div_frac_avg.sv
// Starts the fractional divider, waits for done, then sums 2^LOG2_LEN
// dithered quotients and reports sum plus integer/fractional average.
module div_frac_avg
    import div_frac_avg_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int LOG2_LEN = 8,
    localparam int ACC_W   = acc_width(DATA_W, LOG2_LEN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                div_en,
    input  logic                div_done,
    input  logic [DATA_W-1:0]   div_quotient,
    output logic [ACC_W-1:0]    acc,
    output logic [DATA_W-1:0]   avg_int,
    output logic [LOG2_LEN-1:0] avg_frac,
    output logic                valid,
    output logic                err
);

    state_e           state_q;
    state_e           state_d;
    logic             div_en_q;
    logic             valid_q;
    logic             valid_d;
    logic             err_q;
    logic             err_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    logic             sum_clr;
    logic             sum_load;
    logic             sum_add;
    logic [ACC_W-1:0] sum;
    logic             sum_last;

    div_frac_avg_acc #(
        .DATA_W   (DATA_W),
        .LOG2_LEN (LOG2_LEN),
        .ACC_W    (ACC_W)
    ) u_acc (
        .clk_i    (clk),
        .rst_i    (rst),
        .clr_i    (sum_clr),
        .load_i   (sum_load),
        .add_i    (sum_add),
        .sample_i (div_quotient),
        .sum_o    (sum),
        .last_o   (sum_last)
    );

    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        err_d    = err_q;
        acc_d    = acc_q;
        sum_clr  = 1'b0;
        sum_load = 1'b0;
        sum_add  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT;
                    err_d   = 1'b0;
                    sum_clr = 1'b1;
                end
            end
            ST_WAIT: begin
                if (div_done) begin
                    sum_load = 1'b1;
                    state_d  = ST_ACC;
                end
            end
            ST_ACC: begin
                // a missing done is flagged but the sample still counts
                sum_add = 1'b1;
                if (!div_done) begin
                    err_d = 1'b1;
                end
                if (sum_last) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                acc_d   = sum;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            div_en_q <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            div_en_q <= (state_d != ST_IDLE);
            valid_q  <= valid_d;
            err_q    <= err_d;
            acc_q    <= acc_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign div_en   = div_en_q;
    assign valid    = valid_q;
    assign err      = err_q;
    assign acc      = acc_q;
    assign avg_int  = acc_q[ACC_W-1:LOG2_LEN];
    assign avg_frac = acc_q[LOG2_LEN-1:0];

endmodule

// File: tb/tb_div_frac_avg.sv
// Bench for div_frac_avg: stub divider with fixed latency and patterned
// quotients, run-level model checked every cycle, plus literal checks.
module tb_div_frac_avg;

    localparam int DW = 32;
    localparam int L2 = 4;
    localparam int N  = 16;
    localparam int AW = DW + L2;
    localparam int D  = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          div_en;
    logic          div_done;
    logic [DW-1:0] div_quotient;
    logic [AW-1:0] acc;
    logic [DW-1:0] avg_int;
    logic [L2-1:0] avg_frac;
    logic          valid;
    logic          err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mode = 0;
    bit drop_en = 1'b0;
    int stub_cnt = 0;
    int qidx = 0;
    bit chk_en = 1'b0;
    int valid_cnt = 0;

    div_frac_avg #(.DATA_W(DW), .LOG2_LEN(L2)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .div_en       (div_en),
        .div_done     (div_done),
        .div_quotient (div_quotient),
        .acc          (acc),
        .avg_int      (avg_int),
        .avg_frac     (avg_frac),
        .valid        (valid),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] qfun(input int m, input int k);
        case (m)
            0: return 32'd5;
            1: return (k % 2 == 0) ? 32'd2 : 32'd3;
            2: return (k % 2 == 0) ? 32'd3 : 32'd4;
            3: return 32'd16384;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    // stub divider: done rises D cycles after en, then one quotient per cycle
    always @(posedge clk) begin
        if (div_en !== 1'b1) begin
            stub_cnt <= 0;
            qidx <= 0;
        end else if (stub_cnt < D) begin
            stub_cnt <= stub_cnt + 1;
        end else begin
            qidx <= qidx + 1;
        end
    end

    always_comb begin
        div_done = (div_en === 1'b1) && (stub_cnt >= D);
        if (drop_en && qidx == 5) div_done = 1'b0;
        div_quotient = qfun(mode, qidx);
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // run-level model: a run accepted at an idle edge is busy for D+N+1
    // cycles and then shows its sum with a one-cycle valid
    int            s0 = 0;
    bit            run_act = 1'b0;
    logic [AW-1:0] run_sum = '0;
    logic [AW-1:0] exp_acc = '0;
    bit            run_err = 1'b0;
    bit            exp_err = 1'b0;
    bit            exp_valid;
    bit            exp_busy;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_valid = 1'b0;
            if (run_act && cyc == s0 + D + N + 1) begin
                exp_valid = 1'b1;
                exp_acc = run_sum;
                exp_err = run_err;
                run_act = 1'b0;
            end
            exp_busy = run_act && cyc >= s0 && cyc <= s0 + D + N;
            chk("busy", busy, exp_busy);
            chk("div_en", div_en, exp_busy);
            chk("valid", valid, exp_valid);
            chk("acc", acc, exp_acc);
            chk("avg_int", avg_int, exp_acc / N);
            chk("avg_frac", avg_frac, exp_acc % N);
            if (!exp_busy) chk("err", err, exp_err);
            if (valid === 1'b1) valid_cnt++;
            if (rst) begin
                run_act = 1'b0;
                exp_acc = '0;
                exp_err = 1'b0;
            end else if (start && !exp_busy) begin
                run_act = 1'b1;
                s0 = cyc + 1;
                run_sum = '0;
                for (int k = 0; k < N; k++) run_sum += AW'(qfun(mode, k));
                run_err = drop_en;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_measure(input int m, input bit drop, output int lat);
        mode = m;
        drop_en = drop;
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 1;
        while (valid !== 1'b1 && lat < 200) begin
            step();
            lat++;
        end
        chk("run_timeout", lat < 200, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int v0;
        int low;
        rst = 1'b1;
        start = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_acc", acc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_div_en", div_en, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", err, 0);
        step();

        run_measure(0, 1'b0, lat);
        chk("lat_const5", lat, 23);
        chk("acc_const5", acc, 80);
        chk("int_const5", avg_int, 5);
        chk("frac_const5", avg_frac, 0);
        chk("err_const5", err, 0);
        step();

        run_measure(1, 1'b0, lat);
        chk("acc_alt23", acc, 40);
        chk("int_alt23", avg_int, 2);
        chk("frac_alt23", avg_frac, 8);
        step();

        run_measure(2, 1'b0, lat);
        chk("int_7_2", avg_int, 3);
        chk("frac_7_2", avg_frac, 8);
        step();

        run_measure(3, 1'b0, lat);
        chk("int_2p14", avg_int, 16384);
        chk("frac_2p14", avg_frac, 0);
        step();

        run_measure(4, 1'b0, lat);
        chk("acc_max", acc, 36'hF_FFFF_FFF0);
        chk("int_max", avg_int, 32'hFFFF_FFFF);
        step();

        // start pulses in ACC and in FIN must be ignored
        mode = 0;
        v0 = valid_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (11) step();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (30) step();
        chk("one_valid", valid_cnt - v0, 1);

        // start held: one idle gap in div_en between back-to-back runs
        v0 = valid_cnt;
        low = 0;
        start = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            step();
            if (i == 30) start = 1'b0;
            if (i >= 2 && i <= 40 && div_en !== 1'b1) low++;
        end
        chk("en_gap", low, 1);
        chk("two_valid", valid_cnt - v0, 2);

        // done dropped once mid-ACC: sticky err, full sample count
        run_measure(0, 1'b1, lat);
        chk("drop_err", err, 1);
        chk("drop_acc", acc, 80);
        chk("drop_lat", lat, 23);
        step();
        drop_en = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("err_clr", err, 0);
        repeat (30) step();

        // reset in the third ACC cycle
        v0 = valid_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstacc_busy", busy, 0);
        chk("rstacc_en", div_en, 0);
        chk("rstacc_acc", acc, 0);
        repeat (30) step();
        chk("rstacc_novalid", valid_cnt - v0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
